// File: rtl/donkey_ctl_pkg.sv
// Shared types and constants for the Donkey sprite motion controller.
package donkey_ctl_pkg;

  // Sprite footprint on screen.
  localparam int DONKEY_WIDTH  = 64;
  localparam int DONKEY_HEIGHT = 64;

  // Keyboard codes (PS/2 set-2 make codes) produced by the keyboard decoder.
  localparam logic [15:0] KEY_NONE = 16'h0000;
  localparam logic [15:0] KEY_A    = 16'h001C;
  localparam logic [15:0] KEY_D    = 16'h0023;
  localparam logic [15:0] KEY_W    = 16'h001D;

  // Vertical motion state; velocity direction is implied by the state.
  typedef enum logic [1:0] {GROUND, RISE, FALL} donkey_state_t;

  // True for the keys that steer the sprite horizontally.
  function automatic logic is_horiz(input logic [15:0] key);
    return (key == KEY_A) || (key == KEY_D);
  endfunction

endpackage

// File: rtl/donkey_ctl_if.sv
// Keyboard/timing inputs and sprite-position outputs of the motion controller.
interface donkey_ctl_if;
  logic        vblnk;
  logic [15:0] keycode;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        left;
  logic [15:0] previous;
  logic        airborne;

  modport master (output vblnk, keycode,
                  input  xpos, ypos, left, previous, airborne);
  modport slave  (input  vblnk, keycode,
                  output xpos, ypos, left, previous, airborne);
endinterface

// File: rtl/donkey_ctl_edge_rise.sv
// Generic 1-bit rising-edge detector with a registered pulse output.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);
  logic d_q;
  logic rise_q;

  // Remember the last sample and flag a 0->1 transition for one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q    <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      d_q    <= d_i;
      rise_q <= d_i & ~d_q;
    end
  end

  assign rise_o = rise_q;
endmodule

// File: rtl/donkey_ctl.sv
// Per-frame Donkey motion: horizontal walk with clamps, jump/fall trajectory.
module donkey_ctl
  import donkey_ctl_pkg::*;
#(
  parameter int unsigned X_START = 100,
  parameter int unsigned X_MIN   = 0,
  parameter int unsigned X_MAX   = 1024 - DONKEY_WIDTH,
  parameter int unsigned Y_MIN   = 0,
  parameter int unsigned FLOOR_Y = 704,
  parameter int unsigned STEP_X  = 4,
  parameter int unsigned JUMP_V0 = 12,
  parameter int unsigned GRAVITY = 1,
  parameter int unsigned V_MAX   = 15
) (
  input  logic        clk,
  input  logic        rst,
  donkey_ctl_if.slave bus
);
  // 13-bit versions so add/subtract can never wrap inside the 12-bit screen.
  localparam logic [12:0] XMIN_W  = 13'(X_MIN);
  localparam logic [12:0] XMAX_W  = 13'(X_MAX);
  localparam logic [12:0] STEP_W  = 13'(STEP_X);
  localparam logic [12:0] YMIN_W  = 13'(Y_MIN);
  localparam logic [12:0] FLOOR_W = 13'(FLOOR_Y);
  localparam logic [11:0] XSTART  = 12'(X_START);
  localparam logic [5:0]  V0      = 6'(JUMP_V0);
  localparam logic [5:0]  GRAV    = 6'(GRAVITY);
  localparam logic [5:0]  VMAX    = 6'(V_MAX);

  logic          tick;
  logic [11:0]   xpos_q, xpos_d;
  logic [11:0]   ypos_q, ypos_d;
  logic          left_q, left_d;
  logic [15:0]   prev_q, prev_d;
  logic [5:0]    vel_q, vel_d;
  donkey_state_t state_q, state_d;

  logic [12:0]   x_dec, x_inc, y_dn;
  logic [11:0]   y_up;
  logic [6:0]    v_fall;

  // One tick per frame, on the vblank rising edge.
  edge_rise u_vblnk_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.vblnk),
    .rise_o (tick)
  );

  // Next-state: everything holds unless this is a frame tick.
  always_comb begin
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    left_d  = left_q;
    prev_d  = prev_q;
    vel_d   = vel_q;
    state_d = state_q;

    x_dec  = {1'b0, xpos_q} - STEP_W;
    x_inc  = {1'b0, xpos_q} + STEP_W;
    y_up   = ypos_q - {6'b0, vel_q};
    v_fall = {1'b0, vel_q} + {1'b0, GRAV};
    if (v_fall > {1'b0, VMAX}) v_fall = {1'b0, VMAX};
    y_dn   = {1'b0, ypos_q} + {6'b0, v_fall};

    if (tick) begin
      left_d = (bus.keycode == KEY_A);
      if (is_horiz(bus.keycode)) prev_d = bus.keycode;

      // Horizontal steering works in every vertical state (air control).
      if (bus.keycode == KEY_A) begin
        xpos_d = (x_dec[12] || (x_dec < XMIN_W)) ? XMIN_W[11:0] : x_dec[11:0];
      end else if (bus.keycode == KEY_D) begin
        xpos_d = (x_inc > XMAX_W) ? XMAX_W[11:0] : x_inc[11:0];
      end

      case (state_q)
        GROUND: begin
          // Take-off tick only loads velocity; the sprite moves next tick.
          if (bus.keycode == KEY_W) begin
            state_d = RISE;
            vel_d   = V0;
          end
        end
        RISE: begin
          // ypos - vel <= Y_MIN rewritten as ypos <= Y_MIN + vel (no wrap).
          if ({1'b0, ypos_q} <= YMIN_W + {7'b0, vel_q}) begin
            ypos_d  = YMIN_W[11:0];
            vel_d   = '0;
            state_d = FALL;
          end else begin
            ypos_d = y_up;
            if (vel_q <= GRAV) begin
              vel_d   = '0;
              state_d = FALL;
            end else begin
              vel_d = vel_q - GRAV;
            end
          end
        end
        FALL: begin
          // Landing tick ignores W; a held W jumps again on the next tick.
          if (y_dn >= FLOOR_W) begin
            ypos_d  = FLOOR_W[11:0];
            vel_d   = '0;
            state_d = GROUND;
          end else begin
            ypos_d = y_dn[11:0];
            vel_d  = v_fall[5:0];
          end
        end
        default: state_d = GROUND;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xpos_q  <= XSTART;
      ypos_q  <= FLOOR_W[11:0];
      left_q  <= 1'b0;
      prev_q  <= KEY_NONE;
      vel_q   <= '0;
      state_q <= GROUND;
    end else begin
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      left_q  <= left_d;
      prev_q  <= prev_d;
      vel_q   <= vel_d;
      state_q <= state_d;
    end
  end

  assign bus.xpos     = xpos_q;
  assign bus.ypos     = ypos_q;
  assign bus.left     = left_q;
  assign bus.previous = prev_q;
  assign bus.airborne = (state_q != GROUND);

endmodule
